// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target emulating an MPU6050-style register map with auto-increment pointer.
module i2c_slave_responder #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h68,
  parameter int         REG_ADDR_W    = 4
) (
  input  logic                  clk_4x,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_drive_low,
  input  logic                  host_wr_en,
  input  logic [REG_ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]            host_wr_data,
  output logic                  bus_wr_strobe,
  output logic [REG_ADDR_W-1:0] bus_wr_addr,
  output logic [7:0]            bus_wr_data,
  output logic                  busy
);
  localparam int DEPTH = 2**REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_ACK       = 3'd2;
  localparam logic [2:0] S_RX_PTR    = 3'd3;
  localparam logic [2:0] S_RX_DATA   = 3'd4;
  localparam logic [2:0] S_TX_DATA   = 3'd5;
  localparam logic [2:0] S_TX_ACK    = 3'd6;
  localparam logic [2:0] S_WAIT_STOP = 3'd7;

  logic r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0] r_state, r_ack_next, r_cnt;
  logic r_ack_on, r_tx_load, r_drive, r_busy, r_strobe;
  logic [7:0] r_shift, r_wdata;
  logic [REG_ADDR_W-1:0] r_ptr, r_waddr;
  logic [7:0] r_regs [DEPTH];

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_match, w_bus_we;
  logic [7:0] w_byte;
  logic [REG_ADDR_W-1:0] w_ptr_inc;

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_sda_s2 & ~r_sda_d;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_match    = w_byte[7:1] == SLAVE_ADDRESS;
  assign w_ptr_inc  = r_ptr + PTR_ONE;
  assign w_bus_we   = (r_state == S_RX_DATA) & w_scl_rise & (r_cnt == 3'd7) & ~w_start & ~w_stop;

  assign sda_drive_low = r_drive;
  assign busy          = r_busy;
  assign bus_wr_strobe = r_strobe;
  assign bus_wr_addr   = r_waddr;
  assign bus_wr_data   = r_wdata;

  // Bus write is ordered last so it wins a same-address collision with the host.
  always_ff @(posedge clk_4x) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (host_wr_en) r_regs[host_wr_addr] <= host_wr_data;
      if (w_bus_we) r_regs[r_ptr] <= w_byte;
    end
  end

  always_ff @(posedge clk_4x) begin
    if (!reset) begin
      {r_scl_s1, r_scl_s2, r_scl_d, r_sda_s1, r_sda_s2, r_sda_d} <= '1;
      r_state    <= S_IDLE;
      r_ack_next <= S_IDLE;
      r_cnt      <= '0;
      r_ack_on   <= 1'b0;
      r_tx_load  <= 1'b0;
      r_drive    <= 1'b0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
      r_shift    <= '0;
      r_wdata    <= '0;
      r_waddr    <= '0;
      r_ptr      <= '0;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
      r_strobe <= 1'b0;
      if (w_start) begin
        r_state  <= S_ADDR;
        r_cnt    <= '0;
        r_drive  <= 1'b0;
        r_busy   <= 1'b0;
        r_ack_on <= 1'b0;
      end else if (w_stop) begin
        r_state  <= S_IDLE;
        r_drive  <= 1'b0;
        r_busy   <= 1'b0;
        r_ack_on <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_RX_PTR, S_RX_DATA: if (w_scl_rise) begin
            r_shift <= w_byte;
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
              r_state    <= (r_state != S_ADDR || w_match) ? S_ACK : S_WAIT_STOP;
              r_ack_next <= (r_state == S_ADDR) ? (w_byte[0] ? S_TX_DATA : S_RX_PTR) : S_RX_DATA;
              r_ptr      <= (r_state == S_RX_PTR) ? w_byte[REG_ADDR_W-1:0] :
                            (r_state == S_RX_DATA) ? w_ptr_inc : r_ptr;
              r_strobe   <= r_state == S_RX_DATA;
              if (r_state == S_RX_DATA) begin
                r_waddr <= r_ptr;
                r_wdata <= w_byte;
              end
            end
          end
          S_ACK: if (w_scl_fall) begin
            if (!r_ack_on) begin
              r_drive  <= 1'b1;
              r_busy   <= 1'b1;
              r_ack_on <= 1'b1;
            end else begin
              r_ack_on  <= 1'b0;
              r_cnt     <= '0;
              r_tx_load <= 1'b0;
              r_state   <= r_ack_next;
              r_drive   <= (r_ack_next == S_TX_DATA) & ~r_regs[r_ptr][7];
              r_shift   <= {r_regs[r_ptr][6:0], 1'b0};
            end
          end
          // r_tx_load marks a freshly reloaded byte whose bit7 goes out on this fall.
          S_TX_DATA: if (w_scl_fall) begin
            if (r_tx_load || r_cnt != 3'd7) begin
              r_drive   <= ~r_shift[7];
              r_shift   <= {r_shift[6:0], 1'b0};
              r_cnt     <= r_tx_load ? r_cnt : r_cnt + 3'd1;
              r_tx_load <= 1'b0;
            end else begin
              r_drive <= 1'b0;
              r_state <= S_TX_ACK;
            end
          end
          S_TX_ACK: if (w_scl_rise) begin
            if (!r_sda_s2) begin
              r_ptr     <= w_ptr_inc;
              r_shift   <= r_regs[w_ptr_inc];
              r_tx_load <= 1'b1;
              r_cnt     <= '0;
              r_state   <= S_TX_DATA;
            end else begin
              r_state <= S_WAIT_STOP;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: directed I2C master transactions against the responder with immediate-assertion checks.
module tb_i2c_slave_responder;
  logic clk_4x = 1'b0;
  logic reset = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic host_wr_en = 1'b0;
  logic [3:0] host_wr_addr = '0;
  logic [7:0] host_wr_data = '0;
  logic scl_in, sda_in, sda_drive_low, bus_wr_strobe, busy;
  logic [3:0] bus_wr_addr;
  logic [7:0] bus_wr_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_drive = 0;
  logic [3:0] last_addr = '0;
  logic [7:0] last_data = '0;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_drive_low;

  i2c_slave_responder #(.SLAVE_ADDRESS(7'h68), .REG_ADDR_W(4)) dut (
    .clk_4x(clk_4x), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_drive_low(sda_drive_low), .host_wr_en(host_wr_en),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .bus_wr_strobe(bus_wr_strobe), .bus_wr_addr(bus_wr_addr),
    .bus_wr_data(bus_wr_data), .busy(busy)
  );

  always #5 clk_4x = ~clk_4x;

  always @(posedge clk_4x) begin
    if (bus_wr_strobe) begin
      n_strobe  <= n_strobe + 1;
      last_addr <= bus_wr_addr;
      last_data <= bus_wr_data;
    end
    if (sda_drive_low) n_drive <= n_drive + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: summary not reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q();
    repeat (4) @(posedge clk_4x);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); sda_m = 1'b0; q(); scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q(); scl_m = 1'b1; q(); sda_m = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; q(); scl_m = 1'b1; q(); q(); scl_m = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; q(); scl_m = 1'b1; q(); b = sda_in; q(); scl_m = 1'b0; q();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(nack);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_wr_addr = a; host_wr_data = d; host_wr_en = 1'b1;
    @(posedge clk_4x); #1;
    host_wr_en = 1'b0;
  endtask

  initial begin
    logic a;
    logic seen;
    logic [7:0] d;
    int s0, d0;
    repeat (4) @(posedge clk_4x);
    #1;
    check("rst_drive", sda_drive_low, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_strobe", bus_wr_strobe, 1'b0);
    check("rst_waddr", bus_wr_addr, 4'h0);
    check("rst_wdata", bus_wr_data, 8'h00);
    reset = 1'b1;
    q();

    // write 0xA5 to register 3
    s0 = n_strobe;
    i2c_start();
    wbyte(8'hD0, a); check("t1_ack_addr", a, 1'b0);
    check("t1_busy", busy, 1'b1);
    wbyte(8'h03, a); check("t1_ack_ptr", a, 1'b0);
    wbyte(8'hA5, a); check("t1_ack_data", a, 1'b0);
    i2c_stop();
    check("t1_strobes", n_strobe - s0, 1);
    check("t1_waddr", last_addr, 4'h3);
    check("t1_wdata", last_data, 8'hA5);
    check("t1_busy_stop", busy, 1'b0);
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h03, a);
    i2c_start(); wbyte(8'hD1, a); check("t1_rd_ack", a, 1'b0);
    rbyte(1'b1, d); check("t1_readback", d, 8'hA5);
    i2c_stop();

    // MPU-style register read
    host_write(4'h5, 8'h3C);
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h05, a);
    i2c_start(); wbyte(8'hD1, a); check("t2_ack", a, 1'b0);
    rbyte(1'b1, d); check("t2_data", d, 8'h3C);
    check("t2_busy_before_stop", busy, 1'b1);
    i2c_stop();
    check("t2_busy_after_stop", busy, 1'b0);

    // burst read wrapping 14 -> 15 -> 0
    host_write(4'hE, 8'h11); host_write(4'hF, 8'h22); host_write(4'h0, 8'h33);
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h0E, a);
    i2c_start(); wbyte(8'hD1, a);
    rbyte(1'b0, d); check("t3_b0", d, 8'h11);
    rbyte(1'b0, d); check("t3_b1", d, 8'h22);
    rbyte(1'b1, d); check("t3_b2", d, 8'h33);
    i2c_stop();

    // foreign address: no ACK, no drive, no strobe
    s0 = n_strobe; d0 = n_drive;
    i2c_start();
    wbyte(8'hA0, a); check("t4_nack_addr", a, 1'b1);
    wbyte(8'h00, a); check("t4_nack_data", a, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_drive_cycles", n_drive - d0, 0);
    i2c_stop();
    check("t4_strobes", n_strobe - s0, 0);

    // host/bus collision on register 2; 0x99 = 1001_1001
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h02, a);
    for (int i = 7; i >= 1; i--) wbit(i[0] ^ i[1] ? 1'b0 : 1'b1);
    host_wr_addr = 4'h2; host_wr_data = 8'h55; host_wr_en = 1'b1;
    seen = 1'b0;
    fork
      wbit(1'b1);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          @(posedge clk_4x); #1;
          if (bus_wr_strobe) seen = 1'b1;
        end
        host_wr_en = 1'b0;
      end
    join
    check("t6_strobe_seen", seen, 1'b1);
    rbit(a); check("t6_ack", a, 1'b0);
    i2c_stop();
    check("t6_wdata", last_data, 8'h99);
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h02, a);
    i2c_start(); wbyte(8'hD1, a);
    rbyte(1'b1, d); check("t6_reg2", d, 8'h99);
    i2c_stop();

    // reset while the target is driving a 0 data bit
    host_write(4'h7, 8'h0F); host_write(4'h1, 8'hC3);
    i2c_start(); wbyte(8'hD0, a); wbyte(8'h07, a);
    i2c_start(); wbyte(8'hD1, a); check("t5_ack", a, 1'b0);
    check("t5_driving", sda_drive_low, 1'b1);
    reset = 1'b0;
    @(posedge clk_4x); #1;
    check("t5_drive_released", sda_drive_low, 1'b0);
    check("t5_busy", busy, 1'b0);
    repeat (2) @(posedge clk_4x);
    #1;
    reset = 1'b1;
    i2c_stop();
    host_write(4'h0, 8'h5A);
    i2c_start(); wbyte(8'hD1, a); check("t5_rd_ack", a, 1'b0);
    rbyte(1'b0, d); check("t5_ptr_zero", d, 8'h5A);
    rbyte(1'b1, d); check("t5_reg1_cleared", d, 8'h00);
    i2c_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
